// File: rtl/map_checker_if.sv
// map_checker_if: control and memory-read signals between the map checker and its surroundings
interface map_checker_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [1:0] status;
  logic [7:0] area_a;
  logic [7:0] area_b;
  modport master (
    input  start, mem_rdata,
    output mem_addr, mem_req, busy, done, status, area_a, area_b
  );
  modport slave (
    output start, mem_rdata,
    input  mem_addr, mem_req, busy, done, status, area_a, area_b
  );
endinterface

// File: rtl/map_checker.sv
// map_checker: walks the adjacency index and lists in memory and verifies a four-colour map; define MAP_CHECK_SKIP_EN to skip colour reads of already-checked back edges
module map_checker #(
  parameter int NUM_AREAS  = 33,
  parameter int COLOR_BASE = 0,
  parameter int INDEX_BASE = 33
) (
  input logic           clk,
  input logic           rst_n,
  map_checker_if.master bus
);
  localparam logic [7:0] NA = 8'(NUM_AREAS);
  localparam logic [7:0] CB = 8'(COLOR_BASE);
  localparam logic [7:0] IB = 8'(INDEX_BASE);
  localparam logic [1:0] ST_CONFLICT  = 2'd1;
  localparam logic [1:0] ST_UNCOLORED = 2'd2;
  localparam logic [1:0] ST_BADREF    = 2'd3;
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, RD_CA, RD_NB, RD_CB, NEXT, DONE} state_t;
  state_t     state_q, state_d;
  logic [7:0] i_q, i_d, ptr_q, ptr_d, hi_q, hi_d, ca_q, ca_d, nb_q, nb_d;
  logic [7:0] area_a_q, area_a_d, area_b_q, area_b_d;
  logic [1:0] status_q, status_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic [7:0] addr, rd, ptr_inc;
  assign rd      = bus.mem_rdata;
  assign ptr_inc = ptr_q + 8'd1;
  // Next-state, datapath latching and read address for the current scan step
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    ptr_d    = ptr_q;
    hi_d     = hi_q;
    ca_d     = ca_q;
    nb_d     = nb_q;
    status_d = status_q;
    area_a_d = area_a_q;
    area_b_d = area_b_q;
    addr     = 8'd0;
    case (state_q)
      IDLE: if (bus.start) begin
        status_d = 2'd0;
        area_a_d = 8'd0;
        area_b_d = 8'd0;
        i_d      = 8'd0;
        state_d  = RD_LO;
      end
      RD_LO: begin
        addr    = IB + i_q;
        ptr_d   = rd;
        state_d = RD_HI;
      end
      RD_HI: begin
        addr    = IB + i_q + 8'd1;
        hi_d    = rd;
        state_d = RD_CA;
        if (ptr_q > rd) begin
          status_d = ST_BADREF;
          area_a_d = i_q;
          area_b_d = rd;
          state_d  = DONE;
        end
      end
      RD_CA: begin
        addr    = CB + i_q;
        ca_d    = rd;
        state_d = (ptr_q == hi_q) ? NEXT : RD_NB;
        if (rd == 8'd0) begin
          status_d = ST_UNCOLORED;
          area_a_d = i_q;
          area_b_d = 8'd0;
          state_d  = DONE;
        end
      end
      RD_NB: begin
        addr    = ptr_q;
        nb_d    = rd;
        state_d = RD_CB;
        if (rd >= NA) begin
          status_d = ST_BADREF;
          area_a_d = i_q;
          area_b_d = rd;
          state_d  = DONE;
        end
`ifdef MAP_CHECK_SKIP_EN
        else if (rd < i_q) begin
          ptr_d   = ptr_inc;
          state_d = (ptr_inc == hi_q) ? NEXT : RD_NB;
        end
`endif
      end
      RD_CB: begin
        addr    = CB + nb_q;
        ptr_d   = ptr_inc;
        state_d = (ptr_inc == hi_q) ? NEXT : RD_NB;
        if (rd == ca_q) begin
          ptr_d    = ptr_q;
          status_d = ST_CONFLICT;
          area_a_d = i_q;
          area_b_d = nb_q;
          state_d  = DONE;
        end
      end
      NEXT: begin
        i_d     = i_q + 8'd1;
        state_d = (i_q + 8'd1 == NA) ? DONE : RD_LO;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = state_d == DONE;
  end
  // State and registered outputs; reset aborts any scan immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      i_q      <= 8'd0;
      ptr_q    <= 8'd0;
      hi_q     <= 8'd0;
      ca_q     <= 8'd0;
      nb_q     <= 8'd0;
      status_q <= 2'd0;
      area_a_q <= 8'd0;
      area_b_q <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      ptr_q    <= ptr_d;
      hi_q     <= hi_d;
      ca_q     <= ca_d;
      nb_q     <= nb_d;
      status_q <= status_d;
      area_a_q <= area_a_d;
      area_b_q <= area_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign bus.mem_addr = addr;
  assign bus.mem_req  = busy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.status   = status_q;
  assign bus.area_a   = area_a_q;
  assign bus.area_b   = area_b_q;
endmodule
